// File: rtl/mac_result_reader_if.sv
// ============================================================================
// Module      : mac_result_reader_if
// Description : Bundle of the MAC shadow inputs and the byte-stream output
//               handshake of mac_result_reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mac_result_reader_if;
    logic        ena;
    logic [40:0] mac_out;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        frame_last;
    logic        overflow;

    // Environment side: drives the MAC shadow signals and the consumer ready
    modport master (
        output ena, mac_out, byte_ready,
        input  byte_out, byte_valid, frame_last, overflow
    );

    // Reader side
    modport slave (
        input  ena, mac_out, byte_ready,
        output byte_out, byte_valid, frame_last, overflow
    );
endinterface

`default_nettype wire

// File: rtl/mac_result_reader.sv
// ============================================================================
// Module      : mac_result_reader
// Description : Shadows the MAC enable stream, captures each completed 41-bit
//               accumulation into a small FIFO and streams it out LSB first
//               as bytes over a valid/ready port. Drops are flagged in a
//               sticky overflow bit.
//               Optional macro MAC_READER_HDR_EN prefixes every frame with a
//               header byte {4'hA, seq[3:0]}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_result_reader #(
    parameter int COUNT = 4,   // products per accumulation, 1..16
    parameter int DEPTH = 2    // result FIFO entries, power of two
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    mac_result_reader_if.slave bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
`ifdef MAC_READER_HDR_EN
    localparam logic [2:0] C_LAST_IDX = 3'd6;
`else
    localparam logic [2:0] C_LAST_IDX = 3'd5;
`endif
    localparam logic [3:0]    C_CNT_LAST = 4'(COUNT - 1);
    localparam logic [AW-1:0] C_PTR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] C_FULL     = CW'(DEPTH);

    logic [3:0]    r_cnt;
    logic          r_cap_pend;
    logic [40:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [2:0]    r_idx;
    logic          r_overflow;
`ifdef MAC_READER_HDR_EN
    logic [3:0]    r_seq;
`endif

    logic          w_empty;
    logic          w_full;
    logic          w_xfer;
    logic          w_pop;
    logic          w_push;
    logic [40:0]   w_head;
    logic [7:0]    w_byte;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_FULL);
    assign w_xfer  = !w_empty && bus.byte_ready;
    assign w_pop   = w_xfer && (r_idx == C_LAST_IDX);
    // A pop of the final byte frees the slot in the same cycle, so a push
    // into a full FIFO still succeeds when it coincides with that pop.
    assign w_push  = r_cap_pend && (!w_full || w_pop);
    assign w_head  = r_mem[r_rd_ptr];

    // Shadow the MAC product counter; flag the cycle after a completed result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= 4'd0;
            r_cap_pend <= 1'b0;
        end else begin
            r_cap_pend <= 1'b0;
            if (bus.ena) begin
                if (r_cnt == C_CNT_LAST) begin
                    r_cnt      <= 4'd0;
                    r_cap_pend <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end
        end
    end

    // Result storage; contents need no reset because r_count gates them
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.mac_out;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == C_PTR_LAST) ? '0 : r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == C_PTR_LAST) ? '0 : r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Byte index within the current frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= 3'd0;
        end else if (w_xfer) begin
            r_idx <= (r_idx == C_LAST_IDX) ? 3'd0 : r_idx + 3'd1;
        end
    end

    // Sticky drop flag: a completed result found no free slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (r_cap_pend && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef MAC_READER_HDR_EN
    // Frame sequence number, advanced after each frame's final byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seq <= 4'd0;
        end else if (w_pop) begin
            r_seq <= r_seq + 4'd1;
        end
    end

    // Select the header or the data byte addressed by the frame index
    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            3'd0:    w_byte = {4'hA, r_seq};
            3'd1:    w_byte = w_head[7:0];
            3'd2:    w_byte = w_head[15:8];
            3'd3:    w_byte = w_head[23:16];
            3'd4:    w_byte = w_head[31:24];
            3'd5:    w_byte = w_head[39:32];
            3'd6:    w_byte = {7'b0, w_head[40]};
            default: w_byte = 8'h00;
        endcase
    end
`else
    // Select the data byte addressed by the frame index
    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            3'd0:    w_byte = w_head[7:0];
            3'd1:    w_byte = w_head[15:8];
            3'd2:    w_byte = w_head[23:16];
            3'd3:    w_byte = w_head[31:24];
            3'd4:    w_byte = w_head[39:32];
            3'd5:    w_byte = {7'b0, w_head[40]};
            default: w_byte = 8'h00;
        endcase
    end
`endif

    // Outputs are forced to zero while empty so stale storage never leaks out
    assign bus.byte_out   = w_empty ? 8'h00 : w_byte;
    assign bus.byte_valid = !w_empty;
    assign bus.frame_last = !w_empty && (r_idx == C_LAST_IDX);
    assign bus.overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_mac_result_reader.sv
// ============================================================================
// Module      : tb_mac_result_reader
// Description : Self-checking bench for mac_result_reader. Stimulus pushes
//               expected 41-bit results into a scoreboard queue; a monitor
//               rebuilds each frame's bytes arithmetically and compares.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_result_reader;

    localparam int COUNT = 4;
    localparam int DEPTH = 2;
`ifdef MAC_READER_HDR_EN
    localparam int LAST_IDX = 6;
`else
    localparam int LAST_IDX = 5;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_result_reader_if bus();

    mac_result_reader #(.COUNT(COUNT), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [40:0] exp_q [$];
    logic [40:0] prods [COUNT];
    logic [40:0] prod_in = '0;
    bit          rand_ready = 1'b0;

    // Environment MAC: accumulates one product per ena, restarting each COUNT
    logic [40:0] m_acc;
    int          m_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc <= '0;
            m_cnt <= 0;
        end else if (bus.ena) begin
            m_acc <= (m_cnt == 0) ? prod_in : m_acc + prod_in;
            m_cnt <= (m_cnt == COUNT - 1) ? 0 : m_cnt + 1;
        end
    end
    assign bus.mac_out = m_acc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random consumer readiness when enabled
    always @(posedge clk) begin
        #1;
        if (rand_ready) bus.byte_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: compare every presented byte against the scoreboard head
    int          mon_idx = 0;
    logic [3:0]  mon_seq = 4'd0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_out;
    logic        prev_last;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_idx    = 0;
                mon_seq    = 4'd0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 64'(bus.byte_valid), 64'd1);
                    check("hold_byte", 64'(bus.byte_out), 64'(prev_out));
                    check("hold_last", 64'(bus.frame_last), 64'(prev_last));
                end
                if (bus.byte_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", 64'(bus.byte_out), 64'hDEAD);
                    end else begin
                        logic [7:0]  eb;
                        logic [40:0] sh;
                        int          k;
`ifdef MAC_READER_HDR_EN
                        k = mon_idx - 1;
`else
                        k = mon_idx;
`endif
                        if (k < 0) begin
                            eb = 8'hA0 | {4'h0, mon_seq};
                        end else begin
                            sh = exp_q[0] >> (8 * k);
                            eb = sh[7:0];
                        end
                        check($sformatf("byte%0d", mon_idx), 64'(bus.byte_out), 64'(eb));
                        check("frame_last", 64'(bus.frame_last), 64'(mon_idx == LAST_IDX));
                        if (bus.byte_ready) begin
                            if (mon_idx == LAST_IDX) begin
                                void'(exp_q.pop_front());
                                mon_idx = 0;
                                mon_seq = mon_seq + 4'd1;
                            end else begin
                                mon_idx++;
                            end
                        end
                    end
                end
                prev_stall = bus.byte_valid && !bus.byte_ready;
                prev_out   = bus.byte_out;
                prev_last  = bus.frame_last;
            end
        end
    end

    // One accumulation of prods[]; expected result queued right after edge E
    task automatic issue_acc(input int gap, input bit keep);
        logic [40:0] sum = '0;
        for (int i = 0; i < COUNT; i++) begin
            bus.ena = 1'b1;
            prod_in = prods[i];
            sum     = sum + prods[i];
            tick();
            bus.ena = 1'b0;
            if (i == COUNT - 1) begin
                if (keep) exp_q.push_back(sum);
            end else begin
                repeat (gap) tick();
            end
        end
    endtask

    task automatic set_prods(input logic [40:0] a, input logic [40:0] b);
        for (int i = 0; i < COUNT; i++) prods[i] = a * b;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) check({name, "_timeout"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_valid", 64'(bus.byte_valid), 64'd0);
        check("rst_byte", 64'(bus.byte_out), 64'd0);
        check("rst_last", 64'(bus.frame_last), 64'd0);
        check("rst_overflow", 64'(bus.overflow), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ena        = 1'b0;
        bus.byte_ready = 1'b0;
        tick();
        do_reset();

        // Basic frame: 4 x (3*5) with one idle cycle between products
        bus.byte_ready = 1'b1;
        set_prods(41'd3, 41'd5);
        issue_acc(1, 1'b1);
        @(negedge clk);
        check("latency_e", 64'(bus.byte_valid), 64'd0);
        @(negedge clk);
        check("latency_e1", 64'(bus.byte_valid), 64'd1);
        wait_drain("basic", 50);

        // Truncated maximum: 4 x (FFFFF*FFFFF) wraps at 41 bits
        set_prods(41'hFFFFF, 41'hFFFFF);
        issue_acc(0, 1'b1);
        wait_drain("trunc", 50);

        // Backpressure: first byte held for 10 cycles
        bus.byte_ready = 1'b0;
        set_prods(41'd3, 41'd5);
        issue_acc(0, 1'b1);
        repeat (12) tick();
        check("bp_valid", 64'(bus.byte_valid), 64'd1);
        bus.byte_ready = 1'b1;
        wait_drain("bp", 50);

        // Reset after two bytes of a frame
        set_prods(41'd3, 41'd5);
        issue_acc(0, 1'b1);
        tick();
        tick();
        tick();
        do_reset();
        // Reset mid-accumulation at cnt == 2
        prod_in = 41'd7;
        bus.ena = 1'b1;
        tick();
        tick();
        bus.ena = 1'b0;
        do_reset();
        set_prods(41'd2, 41'd9);
        issue_acc(0, 1'b1);
        wait_drain("post_reset", 50);

        // Overflow: three results into a 2-deep FIFO with no consumer
        bus.byte_ready = 1'b0;
        prods[0] = 41'd15; prods[1] = 41'd15; prods[2] = 41'd15; prods[3] = 41'd15;
        issue_acc(0, 1'b1);
        prods[3] = 41'd16;
        issue_acc(0, 1'b1);
        prods[2] = 41'd16;
        issue_acc(0, 1'b0);
        tick();
        tick();
        check("overflow_set", 64'(bus.overflow), 64'd1);
        bus.byte_ready = 1'b1;
        wait_drain("ovf", 60);
        repeat (10) tick();
        check("ovf_no_third", 64'(bus.byte_valid), 64'd0);
        check("overflow_sticky", 64'(bus.overflow), 64'd1);
        do_reset();

        // Push coinciding with the final-byte pop of a full FIFO
        bus.byte_ready = 1'b0;
        set_prods(41'd1, 41'd11);
        issue_acc(0, 1'b1);
        set_prods(41'd1, 41'd12);
        issue_acc(0, 1'b1);
        tick();
        bus.byte_ready = 1'b1;
        repeat (LAST_IDX - COUNT) tick();
        set_prods(41'd1, 41'd13);
        issue_acc(0, 1'b1);
        wait_drain("pushpop", 80);
        check("pushpop_no_ovf", 64'(bus.overflow), 64'd0);

        // Randomized results with random gaps and random consumer readiness
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            int w = 0;
            while (exp_q.size() > 1 && w < 200) begin
                tick();
                w++;
            end
            for (int i = 0; i < COUNT; i++) begin
                prods[i] = 41'($urandom_range(0, 20'hFFFFF)) * 41'($urandom_range(0, 20'hFFFFF));
            end
            issue_acc($urandom_range(0, 2), 1'b1);
        end
        wait_drain("random", 400);
        rand_ready = 1'b0;
        check("random_no_ovf", 64'(bus.overflow), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mac_result_reader.md
# mac_result_reader

Receive-side companion of the 41-bit accumulating MAC: sits on the MAC's `mac_out` bus and shadows the MAC's enable stream to know exactly when a completed accumulation has been written. Each completed result is captured into a small FIFO and streamed out as bytes, LSB first, over an 8-bit valid/ready port toward the chip's dedicated outputs. Overflow is detected and reported, never silently merged.

## Interface
- `COUNT`, 4: products per accumulation; must match the MAC's `COUNT`; legal range 1..16.
- `DEPTH`, 2: result FIFO entries, power of two, ≥1.

- `clk`  in  1  clock, shared with the MAC.
- `rst_n`  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `ena`  in  1  same signal that drives the MAC's `ena`.
- `mac_out`  in  41  MAC result register.
- `byte_out`  out  8  current output byte; reset 0.
- `byte_valid`  out  1  byte available; reset 0.
- `byte_ready`  in  1  consumer accepts byte.
- `frame_last`  out  1  high with final byte of a frame; reset 0.
- `overflow`  out  1  sticky, result dropped; reset 0.

## Operation
- Shadow counter `cnt`, width 4: on each `ena` cycle, if `cnt == COUNT-1` then `cnt <= 0` and `cap_pend <= 1`; otherwise `cnt <= cnt+1`. Without `ena`, `cnt` holds. `COUNT = 1` completes on every `ena` cycle.
- `cap_pend` is a one-cycle flag. In the cycle it is high, `mac_out` is pushed into the FIFO. `mac_out` is valid in this cycle regardless of `ena`.
- Full FIFO when `cap_pend`: the result is dropped and `overflow <= 1`. `overflow` clears only on reset.
- Simultaneous push and pop of the final byte, with a full FIFO: the pop frees the slot first and the push succeeds. No overflow.
- Frame format: 6 data bytes, LSB first. Byte k = `result[8k+7:8k]` for k = 0..4. Byte 5 = `{7'b0, result[40]}`.
- `byte_valid = !fifo_empty`. `byte_out` is the head entry muxed by byte index `idx` (0..5).
- Transfer = `byte_valid && byte_ready`. On transfer, `idx` increments. When the last byte transfers, `idx` returns to 0 and the head is popped.
- `frame_last = byte_valid && (idx == last)`.
- While `byte_valid && !byte_ready`, `byte_out`, `byte_valid` and `frame_last` are held stable.
- A reset mid-frame or mid-accumulation clears `cnt`, `cap_pend`, the FIFO, `idx`, all outputs and the header sequence counter. The partial frame is discarded.

## Timing
- Edge E: the last `ena` cycle of an accumulation; the MAC writes `out` and `cap_pend` is set.
- Edge E+1: the result is written into the FIFO.
- If the FIFO was empty, `byte_valid` is high in the cycle after E+1 with byte 0. Latency is 2 edges from E to first byte.
- Throughput is one byte per cycle with `byte_ready` held high. A frame occupies 6 cycles (7 with the header).
- Back-to-back results (`COUNT = 1`, `ena` continuous) exceed drain rate; `overflow` results once the FIFO fills.

## Configuration
- `MAC_READER_HDR_EN` defined:
  - Each frame is prefixed with a header byte `{4'hA, seq[3:0]}` and is 7 bytes long (`idx` 0..6, last = 6).
  - `seq` increments, wrapping, after each frame's final byte; reset value 0.
- `MAC_READER_HDR_EN` undefined:
  - No header and no `seq` logic.
  - Frames are 6 bytes (last = 5).

## Test plan
- **Basic frame:** COUNT=4; 4 `ena` cycles of 3×5, with `ena` gapped 1 cycle between products; `byte_ready`=1.
  - Bytes are 3C 00 00 00 00 00.
  - `frame_last` is high on the 6th byte only.
- **Truncated max:** 4 cycles of 20'hFFFFF × 20'hFFFFF.
  - Bytes are 04 00 80 FF FF 01 (0x1FFFF800004).
- **Backpressure:** `byte_ready`=0 for 10 cycles after byte 0 is valid.
  - `byte_out` holds 3C and `byte_valid` holds 1.
  - Releasing `byte_ready` completes the frame unchanged.
- **Overflow:** DEPTH=2, `byte_ready`=0, three complete accumulations giving 60, 61, 62.
  - `overflow`=1.
  - After release, exactly two frames are emitted (60, then 61).
- **Reset mid-frame:** assert `rst_n` low after 2 bytes of a frame, plus mid-accumulation at `cnt`=2.
  - All outputs go to 0.
  - After release, 4 new products yield a fresh frame starting at byte 0.
- **Header (`MAC_READER_HDR_EN`):** two results.
  - Headers are A0 then A1, each followed by 6 data bytes.
  - `frame_last` is high on the 7th byte.
